regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, register count, power of two, minimum 2.
REQ-003 The block SHALL have parameter NRD, default 2, number of read ports, range 1..4.
REQ-004 The block SHALL have parameter NWR, default 2, number of write ports, range 1..2.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port rd_addr, input, NRD*AW, packed read addresses, where AW=log2(NREGS).
REQ-008 The block SHALL have port rd_data, output, NRD*XLEN, packed read data.
REQ-009 The block SHALL have port rd_busy, output, NRD, per read port: addressed register has a pending producer.
REQ-010 The block SHALL have port wr_en, input, NWR, per-port write enable.
REQ-011 The block SHALL have port wr_addr, input, NWR*AW, packed write addresses.
REQ-012 The block SHALL have port wr_data, input, NWR*XLEN, packed write data.
REQ-013 The block SHALL have port mark_en, input, 1, set the busy bit of mark_addr.
REQ-014 The block SHALL have port mark_addr, input, AW, register to mark as pending.

Function
REQ-015 Reads SHALL be combinational: rd_data[k] = reg[rd_addr[k]], zero latency.
REQ-016 Register 0 SHALL always read 0 and never report busy; writes and marks to it SHALL be ignored.
REQ-017 A write with wr_en[j]=1 SHALL update reg[wr_addr[j]] at the rising clk edge.
REQ-018 A write SHALL clear the busy bit of wr_addr[j] at the same edge.
REQ-019 When both write ports target the same address in one cycle, port 1 SHALL win for both data and busy clear.
REQ-020 mark_en=1 SHALL set busy[mark_addr] at the rising edge.
REQ-021 When a mark and a write target the same address in one cycle, the mark SHALL win: data is written and busy ends set.
REQ-022 rd_busy[k] SHALL reflect the registered busy bit only; the bypass of REQ-027 SHALL not alter it.
REQ-023 X or out-of-range addresses SHALL have no required behaviour; the bench SHALL not check them.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, clear all registers to 0 and all busy bits to 0.
REQ-025 During reset, rd_data SHALL be all-zero and rd_busy SHALL be all-zero.
REQ-026 A write or mark pending at reset assertion SHALL be discarded; the first update SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-027 With REGFILE_BYPASS_EN defined, a read whose address matches an active write SHALL return that cycle's wr_data combinationally, using the REQ-019 priority, except for register 0.
REQ-028 Without REGFILE_BYPASS_EN, such a read SHALL return the old value until the next edge.

Structure
REQ-029 A package regfile_pkg SHALL hold the default XLEN, NREGS, NRD and NWR constants and an address-width function clog2.
REQ-030 The busy-bit array with its mark/clear priority SHALL be a sub-module regfile_scoreboard, instantiated once.

Verification
REQ-031 Reset then read all 32 registers on both ports -> every rd_data = 0 and every rd_busy = 0.
REQ-032 Write reg i = i+1 for i = 1..15 on port 0, then read ports 0/1 at addresses i/i+1 -> values i+1 and i+2; reg 16 reads 0.
REQ-033 Write 0xDEAD to reg 0 -> rd_data at address 0 stays 0.
REQ-034 Same cycle: port 0 writes reg 5 = 0x11 and port 1 writes reg 5 = 0x22 -> reg 5 reads 0x22 after the edge.
REQ-035 Mark reg 7, then write reg 7 = 0x99 on a later cycle -> rd_busy is 1 between the two edges and 0 after the write; marking and writing reg 7 in the same cycle -> rd_busy = 1 and data = 0x99.
REQ-036 Write reg 3 = 0xABC while reading reg 3 in the same cycle -> rd_data = 0xABC with REGFILE_BYPASS_EN, old value without it; assert rst_n mid-sequence -> outputs zero at once.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Default geometry of the multi-ported register file and the
//                address-width helper used by regfile_mp / regfile_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int XLEN_DEF  = 64;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int NWR_DEF   = 2;

   // Smallest r with 2**r >= n; callers guarantee n >= 2
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int p = 1; p < n; p = p * 2) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy (pending producer) bits. Writes clear the
//                bit of their target, a mark sets it; the mark takes priority
//                over a same-cycle write. Register 0 is never busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
   parameter int NREGS = 32,
   parameter int NWR   = 2,
   parameter int AW    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic              mark_en,
   input  logic [AW-1:0]     mark_addr,
   output logic [NREGS-1:0]  busy
);

   // Busy bits: clear on write, then set on mark (later assignment wins)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
               busy[wr_addr[j*AW +: AW]] <= 1'b0;
            end
         end
         if (mark_en && (mark_addr != '0)) begin
            busy[mark_addr] <= 1'b1;
         end
      end
   end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Multi-ported register file with combinational reads,
//                prioritised writes (highest write port wins) and a busy-bit
//                scoreboard. Register 0 is hard-wired to zero.
//                Optional feature macro: REGFILE_BYPASS_EN - forwards
//                same-cycle write data to matching read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREGS = NREGS_DEF,
   parameter int NRD   = NRD_DEF,
   parameter int NWR   = NWR_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NRD*clog2(NREGS)-1:0]  rd_addr,
   output logic [NRD*XLEN-1:0]          rd_data,
   output logic [NRD-1:0]               rd_busy,
   input  logic [NWR-1:0]               wr_en,
   input  logic [NWR*clog2(NREGS)-1:0]  wr_addr,
   input  logic [NWR*XLEN-1:0]          wr_data,
   input  logic                         mark_en,
   input  logic [clog2(NREGS)-1:0]      mark_addr
);

   localparam int AW = clog2(NREGS);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;

   // Register storage: ascending port loop lets the highest port win a
   // same-address collision; register 0 keeps its reset value forever
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NWR   (NWR),
      .AW    (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .busy      (busy)
   );

   genvar k;
   generate
      for (k = 0; k < NRD; k++) begin : g_rd
         logic [AW-1:0]   addr;
         logic [XLEN-1:0] data;

         assign addr = rd_addr[k*AW +: AW];

         // Read mux; with bypass, the highest matching write port overrides
         // the stored value (never for register 0 or while in reset)
         always_comb begin
            data = regs[addr];
`ifdef REGFILE_BYPASS_EN
            for (int j = 0; j < NWR; j++) begin
               if (rst_n && wr_en[j] && (addr != '0) &&
                   (wr_addr[j*AW +: AW] == addr)) begin
                  data = wr_data[j*XLEN +: XLEN];
               end
            end
`endif
         end

         assign rd_data[k*XLEN +: XLEN] = data;
         assign rd_busy[k]              = busy[addr];
      end
   endgenerate

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Self-checking bench for regfile_mp (default geometry) with a
//                behavioural array model of registers and busy bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

   localparam int XLEN = 64;
   localparam int NREGS = 32;
   localparam int AW = 5;

   logic              clk;
   logic              rst_n;
   logic [2*AW-1:0]   rd_addr;
   logic [2*XLEN-1:0] rd_data;
   logic [1:0]        rd_busy;
   logic [1:0]        wr_en;
   logic [2*AW-1:0]   wr_addr;
   logic [2*XLEN-1:0] wr_data;
   logic              mark_en;
   logic [AW-1:0]     mark_addr;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_regs [NREGS];
   logic            m_busy [NREGS];

   regfile_mp #(.XLEN(64), .NREGS(32), .NRD(2), .NWR(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .mark_en   (mark_en),
      .mark_addr (mark_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   task automatic model_reset();
      for (int i = 0; i < NREGS; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Apply the inputs that were present at the edge just taken
   task automatic model_edge();
      logic [AW-1:0] a;
      if (!rst_n) return;
      for (int j = 0; j < 2; j++) begin
         a = wr_addr[j*AW +: AW];
         if (wr_en[j] && a != 0) begin
            m_regs[a] = wr_data[j*XLEN +: XLEN];
            m_busy[a] = 1'b0;
         end
      end
      if (mark_en && mark_addr != 0) m_busy[mark_addr] = 1'b1;
   endtask

   function automatic logic [XLEN-1:0] exp_rd(input int k);
      logic [AW-1:0]   a;
      logic [XLEN-1:0] v;
      a = rd_addr[k*AW +: AW];
      v = m_regs[a];
`ifdef REGFILE_BYPASS_EN
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j] && a != 0 && wr_addr[j*AW +: AW] == a) v = wr_data[j*XLEN +: XLEN];
      end
`endif
      if (!rst_n || a == 0) v = '0;
      return v;
   endfunction

   function automatic logic exp_busy(input int k);
      logic [AW-1:0] a;
      a = rd_addr[k*AW +: AW];
      return (rst_n && a != 0) ? m_busy[a] : 1'b0;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      mark_en   = 1'b0;
      mark_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr[0 +: AW]  = AW'(a0);
      rd_addr[AW +: AW] = AW'(a1);
   endtask

   task automatic set_wr(input int j, input int a, input logic [XLEN-1:0] d);
      wr_en[j]               = 1'b1;
      wr_addr[j*AW +: AW]    = AW'(a);
      wr_data[j*XLEN +: XLEN] = d;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      model_reset();
      #1;
      for (int a = 0; a < NREGS; a++) begin
         set_rd(a, NREGS - 1 - a);
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_data[k*XLEN +: XLEN] !== 64'd0) begin
               $display("FAIL reset_data port%0d addr%0d: got %h want 0", k, rd_addr[k*AW +: AW], rd_data[k*XLEN +: XLEN]);
               errors++;
            end
            checks++;
            if (rd_busy[k] !== 1'b0) begin
               $display("FAIL reset_busy port%0d: got %b want 0", k, rd_busy[k]);
               errors++;
            end
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_seq_writes();
      for (int i = 1; i <= 15; i++) begin
         idle();
         set_wr(0, i, 64'(i + 1));
         step();
      end
      idle();
      for (int i = 1; i <= 15; i++) begin
         set_rd(i, i + 1);
         #1;
         checks++;
         if (rd_data[0 +: XLEN] !== 64'(i + 1)) begin
            $display("FAIL seq_p0 addr%0d: got %h want %h", i, rd_data[0 +: XLEN], 64'(i + 1));
            errors++;
         end
         checks++;
         if (rd_data[XLEN +: XLEN] !== ((i == 15) ? 64'd0 : 64'(i + 2))) begin
            $display("FAIL seq_p1 addr%0d: got %h want %h", i + 1, rd_data[XLEN +: XLEN], (i == 15) ? 64'd0 : 64'(i + 2));
            errors++;
         end
      end
   endtask

   task automatic test_reg0();
      idle();
      set_wr(0, 0, 64'hDEAD);
      mark_en = 1'b1;
      mark_addr = '0;
      set_rd(0, 0);
      #1;
      checks++;
      if (rd_data[0 +: XLEN] !== 64'd0) begin
         $display("FAIL reg0_same_cycle: got %h want 0", rd_data[0 +: XLEN]);
         errors++;
      end
      step();
      idle();
      #1;
      checks++;
      if (rd_data[0 +: XLEN] !== 64'd0) begin
         $display("FAIL reg0_data: got %h want 0", rd_data[0 +: XLEN]);
         errors++;
      end
      checks++;
      if (rd_busy[0] !== 1'b0) begin
         $display("FAIL reg0_busy: got %b want 0", rd_busy[0]);
         errors++;
      end
   endtask

   task automatic test_same_addr();
      idle();
      set_wr(0, 5, 64'h11);
      set_wr(1, 5, 64'h22);
      set_rd(4, 6);
      step();
      idle();
      set_rd(5, 5);
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (rd_data[k*XLEN +: XLEN] !== 64'h22) begin
            $display("FAIL same_addr port%0d: got %h want 22", k, rd_data[k*XLEN +: XLEN]);
            errors++;
         end
      end
   endtask

   task automatic test_mark();
      idle();
      set_rd(7, 8);
      mark_en = 1'b1;
      mark_addr = 5'd7;
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1) begin
         $display("FAIL mark_set: got %b want 1", rd_busy[0]);
         errors++;
      end
      step();   // a quiet cycle: busy must hold
      checks++;
      if (rd_busy[0] !== 1'b1) begin
         $display("FAIL mark_hold: got %b want 1", rd_busy[0]);
         errors++;
      end
      set_wr(0, 7, 64'h99);
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || rd_data[0 +: XLEN] !== 64'h99) begin
         $display("FAIL write_clears: got busy %b data %h want 0 / 99", rd_busy[0], rd_data[0 +: XLEN]);
         errors++;
      end
      set_wr(1, 7, 64'h1);
      step();
      idle();
      set_wr(0, 7, 64'h99);
      mark_en = 1'b1;
      mark_addr = 5'd7;
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || rd_data[0 +: XLEN] !== 64'h99) begin
         $display("FAIL mark_wins: got busy %b data %h want 1 / 99", rd_busy[0], rd_data[0 +: XLEN]);
         errors++;
      end
   endtask

   task automatic test_bypass_reset();
      logic [XLEN-1:0] want;
      idle();
      set_rd(3, 3);
      set_wr(0, 3, 64'hABC);
      #1;
`ifdef REGFILE_BYPASS_EN
      want = 64'hABC;
`else
      want = 64'd4;
`endif
      checks++;
      if (rd_data[0 +: XLEN] !== want) begin
         $display("FAIL bypass_same_cycle: got %h want %h", rd_data[0 +: XLEN], want);
         errors++;
      end
      step();
      idle();
      #1;
      checks++;
      if (rd_data[XLEN +: XLEN] !== 64'hABC) begin
         $display("FAIL bypass_after_edge: got %h want abc", rd_data[XLEN +: XLEN]);
         errors++;
      end
      // Reset mid-sequence, with a write and a mark pending
      set_rd(3, 7);
      set_wr(1, 7, 64'h5A5A);
      mark_en = 1'b1;
      mark_addr = 5'd3;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
         $display("FAIL reset_async: got data %h busy %b want 0", rd_data, rd_busy);
         errors++;
      end
      @(posedge clk);
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
         $display("FAIL reset_hold: got data %h busy %b want 0", rd_data, rd_busy);
         errors++;
      end
      idle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
         $display("FAIL reset_discard: got data %h busy %b want 0", rd_data, rd_busy);
         errors++;
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         idle();
         for (int j = 0; j < 2; j++) begin
            if ($urandom_range(0, 2) != 0) set_wr(j, $urandom_range(0, 31), {$urandom, $urandom});
         end
         if ($urandom_range(0, 3) == 0) wr_addr[AW +: AW] = wr_addr[0 +: AW];
         mark_en   = ($urandom_range(0, 2) == 0);
         mark_addr = AW'($urandom_range(0, 31));
         set_rd($urandom_range(0, 31), $urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) rd_addr[0 +: AW] = wr_addr[AW +: AW];
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (rd_data[k*XLEN +: XLEN] !== exp_rd(k)) begin
               $display("FAIL rand_data cyc%0d port%0d: got %h want %h", n, k, rd_data[k*XLEN +: XLEN], exp_rd(k));
               errors++;
            end
            checks++;
            if (rd_busy[k] !== exp_busy(k)) begin
               $display("FAIL rand_busy cyc%0d port%0d: got %b want %b", n, k, rd_busy[k], exp_busy(k));
               errors++;
            end
         end
         step();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      rd_addr = '0;
      idle();
      model_reset();
      #12;
      test_reset();
      test_seq_writes();
      test_reg0();
      test_same_addr();
      test_mark();
      test_bypass_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_regfile_mp
`default_nettype wire
